// File: rtl/add64_chain_seq_if.sv
// Bus bundle for add64_chain_seq: operand beats, downstream adder hookup and result words.
// The in_sub signal exists only when ADD64_CHAIN_SUB_EN is defined.
interface add64_chain_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in1_word;
    logic [63:0] in2_word;
    logic        in_cin;
`ifdef ADD64_CHAIN_SUB_EN
    logic        in_sub;
`endif
    logic [63:0] add_in1;
    logic [63:0] add_in2;
    logic        add_cin;
    logic [63:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_last;
    logic        out_cout;
    logic        busy;

    // Sequencer side.
    modport slave (
        input  in_valid, in1_word, in2_word, in_cin,
`ifdef ADD64_CHAIN_SUB_EN
        input  in_sub,
`endif
        input  add_sum, add_cout, out_ready,
        output in_ready, add_in1, add_in2, add_cin,
        output out_valid, out_sum, out_last, out_cout, busy
    );

    // Producer / adder / consumer side.
    modport master (
        output in_valid, in1_word, in2_word, in_cin,
`ifdef ADD64_CHAIN_SUB_EN
        output in_sub,
`endif
        output add_sum, add_cout, out_ready,
        input  in_ready, add_in1, add_in2, add_cin,
        input  out_valid, out_sum, out_last, out_cout, busy
    );
endinterface

// File: rtl/add64_chain_seq.sv
// Multi-precision add sequencer: chains WORDS 64-bit beats through an external adder, LS word first.
// Optional subtraction (A-B) is enabled by defining ADD64_CHAIN_SUB_EN.
module add64_chain_seq #(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    add64_chain_seq_if.slave  bus
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [63:0]      r_out_sum;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_out_cout;
`ifdef ADD64_CHAIN_SUB_EN
    logic             r_sub;
`endif

    logic             w_first;
    logic             w_last;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_sub;
    logic [63:0]      w_add_in2;
    logic             w_add_cin;

    // Handshake and beat-position decode.
    always_comb begin
        w_first    = (r_idx == {IDX_W{1'b0}});
        w_last     = (r_idx == LAST_IDX);
        w_in_ready = !r_out_valid || bus.out_ready;
        w_accept   = bus.in_valid && w_in_ready;
`ifdef ADD64_CHAIN_SUB_EN
        w_sub      = w_first ? bus.in_sub : r_sub;
`else
        w_sub      = 1'b0;
`endif
    end

    // Adder operand selection; subtract uses A + ~B + 1 with the +1 injected on beat 0.
    always_comb begin
        w_add_in2 = bus.in2_word;
        w_add_cin = 1'b0;
        if (w_sub) begin
            w_add_in2 = ~bus.in2_word;
            w_add_cin = w_first ? 1'b1 : r_carry;
        end else begin
            w_add_in2 = bus.in2_word;
            w_add_cin = w_first ? bus.in_cin : r_carry;
        end
    end

    // Sequencer state, carry chain and the single-entry output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= {IDX_W{1'b0}};
            r_carry     <= 1'b0;
            r_out_sum   <= 64'h0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
`ifdef ADD64_CHAIN_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else if (w_accept) begin
            r_out_sum   <= bus.add_sum;
            r_out_valid <= 1'b1;
`ifdef ADD64_CHAIN_SUB_EN
            r_sub       <= w_sub;
`endif
            if (w_last) begin
                r_out_last <= 1'b1;
                r_out_cout <= bus.add_cout;
                r_idx      <= {IDX_W{1'b0}};
                r_carry    <= 1'b0;
                r_state    <= ST_IDLE;
            end else begin
                r_out_last <= 1'b0;
                r_out_cout <= 1'b0;
                r_idx      <= r_idx + IDX_W'(1);
                r_carry    <= bus.add_cout;
                r_state    <= ST_RUN;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.add_in1   = bus.in1_word;
    assign bus.add_in2   = w_add_in2;
    assign bus.add_cin   = w_add_cin;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_last  = r_out_last;
    assign bus.out_cout  = r_out_cout;
    assign bus.busy      = (r_state == ST_RUN);
endmodule

// File: tb/tb_add64_chain_seq.sv
// Directed self-checking bench for add64_chain_seq (WORDS=4) with a behavioural 64-bit adder.
module tb_add64_chain_seq;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    add64_chain_seq_if u_if ();

    add64_chain_seq #(.WORDS(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    assign {u_if.add_cout, u_if.add_sum} =
        {1'b0, u_if.add_in1} + {1'b0, u_if.add_in2} + {64'h0, u_if.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [63:0] es, input logic el, input logic ec);
        chk({tag, ".valid"}, {63'h0, u_if.out_valid}, 64'h1);
        chk({tag, ".sum"},   u_if.out_sum, es);
        chk({tag, ".last"},  {63'h0, u_if.out_last}, {63'h0, el});
        chk({tag, ".cout"},  {63'h0, u_if.out_cout}, {63'h0, ec});
        chk({tag, ".busy"},  {63'h0, u_if.busy}, {63'h0, !el});
    endtask

    // Present one beat, let it be accepted on the next edge, check the registered result.
    task automatic beat(input string tag, input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic [63:0] es, input logic el, input logic ec);
        u_if.in_valid = 1'b1;
        u_if.in1_word = a;
        u_if.in2_word = b;
        u_if.in_cin   = cin;
        @(posedge clk);
        #1;
        chk_out(tag, es, el, ec);
    endtask

    task automatic idle_cycle();
        u_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in1_word  = 64'h0;
        u_if.in2_word  = 64'h0;
        u_if.in_cin    = 1'b0;
        u_if.out_ready = 1'b1;
`ifdef ADD64_CHAIN_SUB_EN
        u_if.in_sub    = 1'b0;
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.valid", {63'h0, u_if.out_valid}, 64'h0);
        chk("rst.sum",   u_if.out_sum, 64'h0);
        chk("rst.last",  {63'h0, u_if.out_last}, 64'h0);
        chk("rst.cout",  {63'h0, u_if.out_cout}, 64'h0);
        chk("rst.busy",  {63'h0, u_if.busy}, 64'h0);
        chk("rst.ready", {63'h0, u_if.in_ready}, 64'h1);
        rst_n = 1'b1;
        idle_cycle();

        // All-ones + 1: carry ripples through every word.
        beat("ones.w0", ONES, 64'h1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat("ones.w1", ONES, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        beat("ones.w2", ONES, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        beat("ones.w3", ONES, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1);
        idle_cycle();
        chk("ones.drain", {63'h0, u_if.out_valid}, 64'h0);

        // External carry-in on beat 0.
        beat("cin.w0", ONES, 64'h0, 1'b1, 64'h0, 1'b0, 1'b0);
        beat("cin.w1", 64'h0, 64'h0, 1'b0, 64'h1, 1'b0, 1'b0);
        beat("cin.w2", 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        beat("cin.w3", 64'h0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0);
        idle_cycle();

        // Consumer stall after first result.
        beat("stall.w0", 64'h1, 64'd10, 1'b0, 64'd11, 1'b0, 1'b0);
        u_if.out_ready = 1'b0;
        u_if.in1_word  = 64'h2;
        u_if.in2_word  = 64'd20;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall.ready", {63'h0, u_if.in_ready}, 64'h0);
            chk_out("stall.hold", 64'd11, 1'b0, 1'b0);
        end
        u_if.out_ready = 1'b1;
        #1;
        chk("stall.resume", {63'h0, u_if.in_ready}, 64'h1);
        beat("stall.w1", 64'h2, 64'd20, 1'b0, 64'd22, 1'b0, 1'b0);
        beat("stall.w2", 64'h3, 64'd30, 1'b0, 64'd33, 1'b0, 1'b0);
        beat("stall.w3", 64'h4, 64'd40, 1'b0, 64'd44, 1'b1, 1'b0);
        idle_cycle();

        // Reset mid-operation with a pending carry.
        beat("abort.w0", ONES, 64'h1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat("abort.w1", ONES, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        u_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort.valid", {63'h0, u_if.out_valid}, 64'h0);
        chk("abort.sum",   u_if.out_sum, 64'h0);
        chk("abort.busy",  {63'h0, u_if.busy}, 64'h0);
        chk("abort.last",  {63'h0, u_if.out_last}, 64'h0);
        rst_n = 1'b1;
        idle_cycle();
        chk("abort.noemit", {63'h0, u_if.out_valid}, 64'h0);
        beat("post.w0", 64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0);
        beat("post.w1", 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        beat("post.w2", 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        beat("post.w3", 64'h0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b0);

        // Back-to-back operations; carry-out of the first must not leak into the second.
        beat("b2b.a0", ONES, 64'h1, 1'b0, 64'h0, 1'b0, 1'b0);
        beat("b2b.a1", ONES, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        beat("b2b.a2", ONES, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        beat("b2b.a3", ONES, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1);
        beat("b2b.b0", 64'h5, 64'd10, 1'b0, 64'd15, 1'b0, 1'b0);
        beat("b2b.b1", 64'h6, 64'd20, 1'b0, 64'd26, 1'b0, 1'b0);
        beat("b2b.b2", 64'h7, 64'd30, 1'b0, 64'd37, 1'b0, 1'b0);
        beat("b2b.b3", 64'h8, 64'd40, 1'b0, 64'd48, 1'b1, 1'b0);
        idle_cycle();

`ifdef ADD64_CHAIN_SUB_EN
        // 5 - 7 over 256 bits: -2, borrow reported as out_cout=0.
        u_if.in_sub = 1'b1;
        beat("sub.w0", 64'h5, 64'h7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        u_if.in_sub = 1'b0;
        beat("sub.w1", 64'h0, 64'h0, 1'b0, ONES, 1'b0, 1'b0);
        beat("sub.w2", 64'h0, 64'h0, 1'b0, ONES, 1'b0, 1'b0);
        beat("sub.w3", 64'h0, 64'h0, 1'b0, ONES, 1'b1, 1'b0);
        idle_cycle();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/add64_chain_seq.md
ADD64_CHAIN_SEQ -- requirements
Module: add64_chain_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4, giving the number of 64-bit words per multi-precision operation (legal 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operand word beat valid.
REQ-005 SHALL have port in_ready  output  1  sequencer can accept a beat.
REQ-006 SHALL have port in1_word  input  64  operand A word, least-significant word first.
REQ-007 SHALL have port in2_word  input  64  operand B word, least-significant word first.
REQ-008 SHALL have port in_cin  input  1  external carry-in, sampled only on beat 0.
REQ-009 SHALL have ports add_in1/add_in2  output  64 each, and add_cin  output  1: operands to the downstream 64-bit adder.
REQ-010 SHALL have ports add_sum  input  64 and add_cout  input  1: combinational result from that adder.
REQ-011 SHALL have port out_valid  output  1  result word valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result word.
REQ-013 SHALL have port out_sum  output  64  registered result word.
REQ-014 SHALL have port out_last  output  1  marks the final (most-significant) result word.
REQ-015 SHALL have port out_cout  output  1  final carry-out; meaningful only when out_last=1, else 0.
REQ-016 SHALL have port busy  output  1  high while in state RUN.

Function
REQ-017 SHALL implement states IDLE and RUN plus a word index idx (0..WORDS-1) and carry register carry_q.
REQ-018 SHALL assert in_ready = !out_valid || out_ready (single-entry output register, pass-through when drained same cycle).
REQ-019 SHALL define a beat as accepted when in_valid && in_ready at a rising edge.
REQ-020 SHALL drive add_in1=in1_word, add_in2=in2_word, add_cin = (idx==0) ? in_cin : carry_q, combinationally every cycle.
REQ-021 SHALL on each accepted beat register out_sum<=add_sum, out_valid<=1, carry_q<=add_cout, idx<=idx+1; latency accept-to-out_valid is exactly 1 cycle.
REQ-022 SHALL on the beat with idx==WORDS-1 set out_last<=1, out_cout<=add_cout, idx<=0, carry_q<=0, state<=IDLE.
REQ-023 SHALL transition IDLE->RUN on beat 0 accept; RUN stays until the last beat is accepted.
REQ-024 SHALL clear out_valid when out_ready is high and no new beat is accepted that cycle; simultaneous drain+accept keeps out_valid=1 with new data.
REQ-025 SHALL hold out_sum/out_last/out_cout stable while out_valid && !out_ready.
REQ-026 SHALL treat add_sum/add_cout as 64-bit modulo with carry; no saturation, no wrap detection beyond out_cout.
REQ-027 SHALL allow back-to-back operations: beat 0 of the next operation may be accepted the cycle after the last beat of the previous.

Reset
REQ-028 SHALL on rst_n=0 at a clock edge set state=IDLE, idx=0, carry_q=0, out_valid=0, out_sum=0, out_last=0, out_cout=0, busy=0.
REQ-029 SHALL abandon a partially accepted operation on reset mid-RUN; no result word for it is emitted afterwards.

Configuration
REQ-030 SHALL, when macro ADD64_CHAIN_SUB_EN is defined, add port in_sub  input  1, sampled on beat 0 and held for the operation, which drives add_in2=~in2_word and forces beat-0 add_cin=1 (ignoring in_cin) to compute A-B; out_cout=1 then means no borrow.
REQ-031 SHALL, without ADD64_CHAIN_SUB_EN, have no in_sub port and perform addition only.

Verification
REQ-032 SHALL cover: WORDS=4, A=all ones (256b), B=1, cin=0, out_ready=1 -> four words 0, out_last on 4th, out_cout=1.
REQ-033 SHALL cover: A word0=0xFFFF_FFFF_FFFF_FFFF, B word0=0, cin=1, other words 0 -> word0=0, word1=1, out_cout=0.
REQ-034 SHALL cover: out_ready held low 3 cycles after first result -> in_ready=0, out_sum stable, no beat lost, resumes in order.
REQ-035 SHALL cover: rst_n low after beat 2 of 4 -> outputs zero next cycle, busy=0, next operation's beat 0 uses in_cin, not stale carry.
REQ-036 SHALL cover: two operations back-to-back with continuous in_valid -> 8 result words, out_last on words 4 and 8, carry not leaked between operations.
REQ-037 SHALL cover (ADD64_CHAIN_SUB_EN): in_sub=1, A=5, B=7 -> all words 0xFFFF_FFFF_FFFF_FFFE.. then 0xFFFF_FFFF_FFFF_FFFF, out_cout=0.
